// File: rtl/ti_link_pkg.sv
// Shared TI-link definitions: command codes, parser/fetcher state encodings
// and the helper that tells which commands carry a payload.
package ti_link_pkg;

  localparam logic [7:0] CMD_VAR  = 8'h06;
  localparam logic [7:0] CMD_DATA = 8'h15;
  localparam logic [7:0] CMD_SKIP = 8'h36;
  localparam logic [7:0] CMD_DEL  = 8'h88;
  localparam logic [7:0] CMD_REQ  = 8'hA2;
  localparam logic [7:0] CMD_RTS  = 8'hC9;
  localparam logic [7:0] CMD_ACK  = 8'h56;
  localparam logic [7:0] CMD_CTS  = 8'h09;
  localparam logic [7:0] CMD_RDY  = 8'h68;

  typedef enum logic [2:0] {
    S_MID,
    S_CID,
    S_LENL,
    S_LENH,
    S_DATA,
    S_CSL,
    S_CSH
  } parse_state_t;

  typedef enum logic {
    F_IDLE,
    F_ACK
  } fetch_state_t;

  // Commands followed by a payload and a trailing 16-bit checksum.
  function automatic logic has_data(input logic [7:0] cid);
    case (cid)
      CMD_VAR, CMD_DATA, CMD_SKIP, CMD_DEL, CMD_REQ, CMD_RTS: has_data = 1'b1;
      default:                                                has_data = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ti_byte_fetch.sv
// Byte fetcher for an avail/read FIFO. Read stays high until avail is seen
// low, so every byte is taken exactly once regardless of the FIFO's ack
// latency. Emits the captured byte plus a one-cycle strobe.
module ti_byte_fetch
  import ti_link_pkg::*;
(
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic [7:0] i_data,
  input  logic       i_avail,
  output logic       o_read,
  output logic [7:0] o_byte,
  output logic       o_strobe
);

  fetch_state_t state_q, state_d;

  // Handshake state register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) state_q <= F_IDLE;
    else         state_q <= state_d;
  end

  // Next state: take a byte when offered, then wait for the FIFO to withdraw it.
  // NOTE: the default assignment first keeps this block free of inferred latches.
  always_comb begin
    state_d = state_q;
    case (state_q)
      F_IDLE:  if (i_avail)  state_d = F_ACK;
      F_ACK:   if (!i_avail) state_d = F_IDLE;
      default: state_d = F_IDLE;
    endcase
  end

  // Capture the byte and raise the strobe on the accepting edge.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      o_byte   <= 8'h00;
      o_strobe <= 1'b0;
    end else begin
      o_strobe <= (state_q == F_IDLE) && i_avail;
      if ((state_q == F_IDLE) && i_avail) o_byte <= i_data;
    end
  end

  assign o_read = (state_q == F_ACK);

endmodule

// File: rtl/ti_packet_rx.sv
// TI-link packet receiver: fetches bytes from the RX FIFO, decodes the
// header, forwards the payload, checks the 16-bit sum and aborts packets
// that stall longer than c_TIMEOUT cycles between bytes.
module ti_packet_rx
  import ti_link_pkg::*;
#(
  parameter int c_TIMEOUT = 1000000
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic [7:0]  i_data,
  input  logic        i_avail,
  output logic        o_read,
  output logic [7:0]  o_mid,
  output logic [7:0]  o_cid,
  output logic [15:0] o_len,
  output logic        o_hdr_valid,
  output logic [7:0]  o_data,
  output logic        o_data_valid,
  output logic        o_done,
  output logic        o_csum_ok,
  output logic        o_error,
  output logic        o_busy
);

  localparam int TW = $clog2(c_TIMEOUT + 1);

  logic [7:0]   rx_byte;
  logic         strobe;
  parse_state_t state_q, state_d;
  logic [7:0]   low_q, low_d;
  logic [15:0]  sum_q, sum_d;
  logic [15:0]  cnt_q, cnt_d;
  logic [TW-1:0] tcnt_q;
  logic         timeout;
  logic [7:0]   mid_d, cid_d, data_d;
  logic [15:0]  len_d;
  logic         ok_d, hdr_d, dv_d, done_d, err_d;

  ti_byte_fetch u_fetch (
    .i_clock  (i_clock),
    .i_reset  (i_reset),
    .i_data   (i_data),
    .i_avail  (i_avail),
    .o_read   (o_read),
    .o_byte   (rx_byte),
    .o_strobe (strobe)
  );

  // A byte arriving in the expiry cycle takes priority over the abort.
  assign timeout = !strobe && (tcnt_q == TW'(c_TIMEOUT));
  assign o_busy  = (state_q != S_MID);

  // Inter-byte timeout counter, idle while waiting for a packet start.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset)                                     tcnt_q <= '0;
    else if (strobe || state_q == S_MID || timeout)  tcnt_q <= '0;
    else                                             tcnt_q <= tcnt_q + 1'b1;
  end

  // Parser state register.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) state_q <= S_MID;
    else         state_q <= state_d;
  end

  // Next-state and next-output decode, advancing one field per byte strobe.
  always_comb begin
    state_d = state_q;
    mid_d   = o_mid;
    cid_d   = o_cid;
    len_d   = o_len;
    data_d  = o_data;
    ok_d    = o_csum_ok;
    low_d   = low_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    hdr_d   = 1'b0;
    dv_d    = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    if (strobe) begin
      case (state_q)
        S_MID: begin
          mid_d   = rx_byte;
          state_d = S_CID;
        end
        S_CID: begin
          cid_d   = rx_byte;
          state_d = S_LENL;
        end
        S_LENL: begin
          low_d   = rx_byte;
          state_d = S_LENH;
        end
        S_LENH: begin
          len_d = {rx_byte, low_q};
          hdr_d = 1'b1;
          sum_d = '0;
          cnt_d = '0;
          if (!has_data(o_cid)) begin
            done_d  = 1'b1;
            ok_d    = 1'b1;
            state_d = S_MID;
          end else if ({rx_byte, low_q} == 16'h0000) begin
            state_d = S_CSL;
          end else begin
            state_d = S_DATA;
          end
        end
        S_DATA: begin
          data_d = rx_byte;
          dv_d   = 1'b1;
          sum_d  = sum_q + {8'h00, rx_byte};
          cnt_d  = cnt_q + 16'd1;
          if (cnt_q + 16'd1 == o_len) state_d = S_CSL;
        end
        S_CSL: begin
          low_d   = rx_byte;
          state_d = S_CSH;
        end
        S_CSH: begin
          ok_d    = ({rx_byte, low_q} == sum_q);
          done_d  = 1'b1;
          state_d = S_MID;
        end
        default: state_d = S_MID;
      endcase
    end else if (timeout) begin
      err_d   = 1'b1;
      state_d = S_MID;
      sum_d   = '0;
      cnt_d   = '0;
    end
  end

  // Registered outputs and parser working registers.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      o_mid        <= 8'h00;
      o_cid        <= 8'h00;
      o_len        <= 16'h0000;
      o_data       <= 8'h00;
      o_csum_ok    <= 1'b0;
      o_hdr_valid  <= 1'b0;
      o_data_valid <= 1'b0;
      o_done       <= 1'b0;
      o_error      <= 1'b0;
      low_q        <= 8'h00;
      sum_q        <= 16'h0000;
      cnt_q        <= 16'h0000;
    end else begin
      o_mid        <= mid_d;
      o_cid        <= cid_d;
      o_len        <= len_d;
      o_data       <= data_d;
      o_csum_ok    <= ok_d;
      o_hdr_valid  <= hdr_d;
      o_data_valid <= dv_d;
      o_done       <= done_d;
      o_error      <= err_d;
      low_q        <= low_d;
      sum_q        <= sum_d;
      cnt_q        <= cnt_d;
    end
  end

endmodule

// File: tb/tb_ti_packet_rx.sv
// Directed bench for ti_packet_rx with a behavioural RX FIFO whose ack
// latency is selectable, and a monitor that logs every output pulse.
module tb_ti_packet_rx;

  localparam int TIMEOUT = 50;

  logic        i_clock = 1'b0;
  logic        i_reset = 1'b0;
  logic [7:0]  i_data;
  logic        i_avail;
  logic        o_read;
  logic [7:0]  o_mid;
  logic [7:0]  o_cid;
  logic [15:0] o_len;
  logic        o_hdr_valid;
  logic [7:0]  o_data;
  logic        o_data_valid;
  logic        o_done;
  logic        o_csum_ok;
  logic        o_error;
  logic        o_busy;

  int checks = 0;
  int errors = 0;

  // FIFO model state
  logic [7:0] fifo_q[$];
  int lat = 1;
  int ack_cnt = 0;
  int pops = 0;

  // Monitor state
  int hdr_cnt = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int read_rises = 0;
  logic read_prev = 1'b0;
  logic [7:0] last_mid;
  logic [7:0] last_cid;
  logic [15:0] last_len;
  logic last_ok;
  logic [7:0] data_q[$];

  ti_packet_rx #(.c_TIMEOUT(TIMEOUT)) dut (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_data       (i_data),
    .i_avail      (i_avail),
    .o_read       (o_read),
    .o_mid        (o_mid),
    .o_cid        (o_cid),
    .o_len        (o_len),
    .o_hdr_valid  (o_hdr_valid),
    .o_data       (o_data),
    .o_data_valid (o_data_valid),
    .o_done       (o_done),
    .o_csum_ok    (o_csum_ok),
    .o_error      (o_error),
    .o_busy       (o_busy)
  );

  always #5 i_clock = ~i_clock;

  // FIFO: presents a byte, withdraws it lat+1 falling edges after read is seen.
  initial begin
    i_avail = 1'b0;
    i_data  = 8'h00;
    forever begin
      @(negedge i_clock);
      if (i_reset) begin
        i_avail = 1'b0;
        ack_cnt = 0;
      end else if (i_avail) begin
        if (o_read) begin
          ack_cnt++;
          if (ack_cnt == lat + 1) begin
            i_avail = 1'b0;
            ack_cnt = 0;
            pops++;
          end
        end
      end else if (fifo_q.size() != 0) begin
        i_data  = fifo_q.pop_front();
        i_avail = 1'b1;
      end
    end
  end

  // Monitor: samples outputs on the falling edge, away from register updates.
  initial begin
    forever begin
      @(negedge i_clock);
      if (o_hdr_valid) begin
        hdr_cnt++;
        last_mid = o_mid;
        last_cid = o_cid;
        last_len = o_len;
      end
      if (o_data_valid) data_q.push_back(o_data);
      if (o_done) begin
        done_cnt++;
        last_ok = o_csum_ok;
      end
      if (o_error) err_cnt++;
      if (o_read && !read_prev) read_rises++;
      read_prev = o_read;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge i_clock);
    #1;
  endtask

  task automatic clear_stats();
    hdr_cnt    = 0;
    done_cnt   = 0;
    err_cnt    = 0;
    read_rises = 0;
    pops       = 0;
    last_ok    = 1'bx;
    data_q.delete();
  endtask

  // Wait until the FIFO is empty and the handshake idle, then let pulses settle.
  task automatic drain(input string name);
    int n = 0;
    while ((fifo_q.size() != 0 || i_avail || o_read) && n < 5000) begin
      tick(1);
      n++;
    end
    if (n >= 5000) begin
      checks++;
      errors++;
      $display("FAIL %s drain bound expired after %0d cycles", name, n);
    end
    tick(6);
  endtask

  task automatic check_all_zero(input string name);
    logic [51:0] obs;
    obs = {o_read, o_hdr_valid, o_data_valid, o_done, o_error, o_busy, o_csum_ok,
           o_mid, o_cid, o_data, o_len, 5'b0};
    checks++;
    if (obs !== 52'h0) begin
      errors++;
      $display("FAIL %s outputs got %h want 0", name, obs);
    end
  endtask

  task automatic push_ack();
    logic [7:0] pkt[4] = '{8'h89, 8'h56, 8'h00, 8'h00};
    foreach (pkt[i]) fifo_q.push_back(pkt[i]);
  endtask

  task automatic push_var(input logic [7:0] cs_lo);
    logic [7:0] pkt[9] = '{8'h08, 8'h06, 8'h03, 8'h00, 8'h01, 8'h02, 8'h03, 8'h00, 8'h00};
    pkt[7] = cs_lo;
    foreach (pkt[i]) fifo_q.push_back(pkt[i]);
  endtask

  task automatic check_ack(input string name);
    checks++;
    if (hdr_cnt !== 1 || last_mid !== 8'h89 || last_cid !== 8'h56 || last_len !== 16'h0000) begin
      errors++;
      $display("FAIL %s_hdr got cnt=%0d mid=%h cid=%h len=%h want cnt=1 mid=89 cid=56 len=0000",
               name, hdr_cnt, last_mid, last_cid, last_len);
    end
    checks++;
    if (done_cnt !== 1 || last_ok !== 1'b1) begin
      errors++;
      $display("FAIL %s_done got cnt=%0d ok=%b want cnt=1 ok=1", name, done_cnt, last_ok);
    end
    checks++;
    if (data_q.size() !== 0) begin
      errors++;
      $display("FAIL %s_nodata got %0d data pulses want 0", name, data_q.size());
    end
    checks++;
    if (o_busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_busy got %b want 0", name, o_busy);
    end
  endtask

  task automatic check_var(input string name, input logic want_ok);
    checks++;
    if (last_len !== 16'h0003 || last_cid !== 8'h06 || last_mid !== 8'h08) begin
      errors++;
      $display("FAIL %s_hdr got mid=%h cid=%h len=%h want mid=08 cid=06 len=0003",
               name, last_mid, last_cid, last_len);
    end
    checks++;
    if (data_q.size() !== 3) begin
      errors++;
      $display("FAIL %s_count got %0d data pulses want 3", name, data_q.size());
    end else begin
      checks++;
      if (data_q[0] !== 8'h01 || data_q[1] !== 8'h02 || data_q[2] !== 8'h03) begin
        errors++;
        $display("FAIL %s_bytes got %h %h %h want 01 02 03", name, data_q[0], data_q[1], data_q[2]);
      end
    end
    checks++;
    if (done_cnt !== 1 || last_ok !== want_ok) begin
      errors++;
      $display("FAIL %s_done got cnt=%0d ok=%b want cnt=1 ok=%b", name, done_cnt, last_ok, want_ok);
    end
  endtask

  task automatic apply_reset(input string name);
    i_reset = 1'b1;
    fifo_q.delete();
    tick(3);
    check_all_zero({name, "_during"});
    i_reset = 1'b0;
    tick(2);
    check_all_zero({name, "_after"});
  endtask

  task automatic test_reset();
    apply_reset("reset");
  endtask

  task automatic test_ack();
    clear_stats();
    push_ack();
    drain("ack");
    check_ack("ack");
  endtask

  task automatic test_var();
    clear_stats();
    push_var(8'h06);
    drain("var");
    check_var("var", 1'b1);
  endtask

  task automatic test_bad_csum();
    clear_stats();
    push_var(8'h07);
    drain("bad");
    check_var("bad", 1'b0);
    clear_stats();
    push_ack();
    drain("bad_next");
    check_ack("bad_next");
  endtask

  task automatic test_long();
    int bad = 0;
    clear_stats();
    fifo_q.push_back(8'h08);
    fifo_q.push_back(8'h15);
    fifo_q.push_back(8'h02);
    fifo_q.push_back(8'h01);
    repeat (258) fifo_q.push_back(8'hFF);
    fifo_q.push_back(8'hFE);
    fifo_q.push_back(8'h00);
    drain("long");
    checks++;
    if (last_len !== 16'h0102) begin
      errors++;
      $display("FAIL long_len got %h want 0102", last_len);
    end
    foreach (data_q[i]) if (data_q[i] !== 8'hFF) bad++;
    checks++;
    if (data_q.size() !== 258 || bad != 0) begin
      errors++;
      $display("FAIL long_data got %0d pulses (%0d not FF) want 258 all FF", data_q.size(), bad);
    end
    checks++;
    if (done_cnt !== 1 || last_ok !== 1'b1) begin
      errors++;
      $display("FAIL long_done got cnt=%0d ok=%b want cnt=1 ok=1", done_cnt, last_ok);
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    clear_stats();
    fifo_q.push_back(8'h08);
    fifo_q.push_back(8'h06);
    drain("to_start");
    checks++;
    if (o_busy !== 1'b1 || err_cnt !== 0) begin
      errors++;
      $display("FAIL to_stalled got busy=%b err=%0d want busy=1 err=0", o_busy, err_cnt);
    end
    while (err_cnt == 0 && n < 200) begin
      tick(1);
      n++;
    end
    tick(3);
    checks++;
    if (err_cnt !== 1) begin
      errors++;
      $display("FAIL to_error got %0d error pulses want 1", err_cnt);
    end
    checks++;
    if (o_busy !== 1'b0 || done_cnt !== 0 || hdr_cnt !== 0) begin
      errors++;
      $display("FAIL to_abort got busy=%b done=%0d hdr=%0d want 0 0 0", o_busy, done_cnt, hdr_cnt);
    end
    clear_stats();
    push_ack();
    drain("to_next");
    check_ack("to_next");
  endtask

  task automatic test_reset_mid();
    int n = 0;
    lat = 2;
    clear_stats();
    fifo_q.push_back(8'h08);
    fifo_q.push_back(8'h06);
    fifo_q.push_back(8'h05);
    fifo_q.push_back(8'h00);
    fifo_q.push_back(8'h0A);
    fifo_q.push_back(8'h0B);
    fifo_q.push_back(8'h0C);
    fifo_q.push_back(8'h0D);
    fifo_q.push_back(8'h0E);
    fifo_q.push_back(8'h3C);
    fifo_q.push_back(8'h00);
    while ((data_q.size() < 2 || i_avail || o_read) && n < 2000) begin
      tick(1);
      n++;
    end
    checks++;
    if (n >= 2000) begin
      errors++;
      $display("FAIL rmid_wait bound expired got %0d data pulses want 2", data_q.size());
    end
    checks++;
    if (read_rises !== pops) begin
      errors++;
      $display("FAIL rmid_once got %0d read acks want %0d bytes", read_rises, pops);
    end
    checks++;
    if (o_busy !== 1'b1 || done_cnt !== 0) begin
      errors++;
      $display("FAIL rmid_indata got busy=%b done=%0d want busy=1 done=0", o_busy, done_cnt);
    end
    apply_reset("rmid");
    tick(5);
    checks++;
    if (done_cnt !== 0 || err_cnt !== 0) begin
      errors++;
      $display("FAIL rmid_discard got done=%0d err=%0d want 0 0", done_cnt, err_cnt);
    end
    clear_stats();
    push_var(8'h06);
    drain("rmid_var");
    check_var("rmid_var", 1'b1);
    checks++;
    if (read_rises !== 9 || pops !== 9) begin
      errors++;
      $display("FAIL rmid_var_once got acks=%0d pops=%0d want 9 9", read_rises, pops);
    end
  endtask

  initial begin
    test_reset();
    test_ack();
    test_var();
    test_bad_csum();
    test_long();
    test_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
